// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing helper, RX state encoding, data width.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_PARITY    = 3'd3,
      RX_STOP      = 3'd4,
      RX_WAIT_HIGH = 3'd5
   } rx_state_t;

   // clk_fre in MHz; result truncates, matching the TX side so both agree on bit length.
   function automatic int cycles_per_bit(input int clk_fre, input int baud_rate);
      return (clk_fre * 1_000_000) / baud_rate;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head visible on pop_data whenever not empty (0 when empty).
// Push accepted when not full or when popping the same cycle; level updates one cycle after.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (PTR_W+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (PTR_W+1)'(1);
            2'b01:   level <= level - (PTR_W+1)'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (8E1 with UART_RX_PARITY_EN) feeding a FWFT FIFO on a valid/ready port.
// Byte valid one cycle after the stop sample; a full FIFO with no pop drops the byte and pulses overrun.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FRE    = 27,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx_pin,
   output logic [7:0]                    rx_data,
   output logic                          rx_data_valid,
   input  logic                          rx_data_ready,
   output logic                          frame_err,
   output logic                          overrun,
`ifdef UART_RX_PARITY_EN
   output logic                          parity_err,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FRE, BAUD_RATE);
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int CNT_W          = $clog2(CYCLES_PER_BIT);

   rx_state_t               state;
   rx_state_t               state_next;
   logic                    rx_meta;
   logic                    rx_sync;
   logic                    rx_prev;
   logic [CNT_W-1:0]        cnt;
   logic [2:0]              bit_idx;
   logic [UART_DATA_W-1:0]  shift_reg;
   logic                    half_tick;
   logic                    bit_tick;
   logic                    push_req;
   logic                    frame_stb;
   logic                    parity_stb;
   logic                    parity_fail;
   logic                    fifo_full;
   logic                    fifo_empty;

   assign half_tick = (cnt == CNT_W'(HALF_BIT - 1));
   assign bit_tick  = (cnt == CNT_W'(CYCLES_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_pin;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RX_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RX_IDLE:      if (rx_prev && !rx_sync) state_next = RX_START;
         RX_START:     if (half_tick) state_next = rx_sync ? RX_IDLE : RX_DATA;
`ifdef UART_RX_PARITY_EN
         RX_DATA:      if (bit_tick && bit_idx == 3'd7) state_next = RX_PARITY;
         RX_PARITY:    if (bit_tick) state_next = RX_STOP;
`else
         RX_DATA:      if (bit_tick && bit_idx == 3'd7) state_next = RX_STOP;
`endif
         RX_STOP:      if (bit_tick) state_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
         RX_WAIT_HIGH: if (rx_sync) state_next = RX_IDLE;
         default:      state_next = RX_IDLE;
      endcase
   end

   // Stop bit decides the fate of the byte: framing beats parity, parity beats push.
   always_comb begin
      push_req   = 1'b0;
      frame_stb  = 1'b0;
      parity_stb = 1'b0;
      if (state == RX_STOP && bit_tick) begin
         if (!rx_sync)         frame_stb  = 1'b1;
         else if (parity_fail) parity_stb = 1'b1;
         else                  push_req   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (state_next != state || bit_tick) cnt <= '0;
         else                                 cnt <= cnt + CNT_W'(1);
         if (state != RX_DATA)  bit_idx <= '0;
         else if (bit_tick)     bit_idx <= bit_idx + 3'd1;
         if (state == RX_DATA && bit_tick) shift_reg <= {rx_sync, shift_reg[7:1]};
         frame_err <= frame_stb;
         overrun   <= push_req && fifo_full && !rx_data_ready;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (state == RX_PARITY && bit_tick) par_bit <= rx_sync;
         parity_err <= parity_stb;
      end
   end

   // Even parity: data ones plus parity bit must be even.
   assign parity_fail = ^shift_reg ^ par_bit;
`else
   assign parity_fail = 1'b0;
`endif

   sync_fifo_fwft #(
      .WIDTH (UART_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_req),
      .push_data (shift_reg),
      .pop       (rx_data_ready),
      .pop_data  (rx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign rx_data_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: expected bytes queued at stimulus time, checked by a pop monitor.
module tb_uart_rx_fifo;

   localparam int BIT = 234;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 2226 + BIT;
`else
   localparam int LAT = 2226;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_pin = 1'b1;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_data_ready = 1'b0;
   logic       frame_err;
   logic       overrun;
   logic [4:0] fifo_level;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   logic       par_flip = 1'b0;
   int         n_perr = 0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n_ferr = 0;
   int n_ovr = 0;
   int cyc = 0;
   int last_rise = -1;
   logic prev_valid = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] msg [15] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F,
                            8'h72, 8'h6C, 8'h64, 8'h20, 8'h41, 8'h0D, 8'h0A};

   uart_rx_fifo dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_pin        (rx_pin),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready),
      .frame_err     (frame_err),
      .overrun       (overrun),
`ifdef UART_RX_PARITY_EN
      .parity_err    (parity_err),
`endif
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
      end
   endtask

   // Scoreboard monitor: every accepted byte must match the head of the expected queue.
   always @(negedge clk) begin
      if (rx_data_valid && !prev_valid) last_rise = cyc;
      prev_valid = rx_data_valid;
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_perr++;
`endif
      if (rst_n && rx_data_valid && rx_data_ready) begin
         if (exp_q.size() == 0) check("unexpected_byte", int'(rx_data), -1);
         else                   check("rx_byte", int'(rx_data), int'(exp_q.pop_front()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx_pin = 1'b0;
      tick(BIT);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         tick(BIT);
      end
`ifdef UART_RX_PARITY_EN
      rx_pin = (^b) ^ par_flip;
      tick(BIT);
`endif
      rx_pin = stop_bit;
      tick(BIT);
      rx_pin = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3000 && rx_data_valid; i++) tick(1);
      check(name, int'(rx_data_valid), 0);
   endtask

   initial begin
      int t0;
      int base;

      tick(3);
      check("rst_rx_data", int'(rx_data), 0);
      check("rst_valid", int'(rx_data_valid), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_level", int'(fifo_level), 0);
      rst_n = 1'b1;
      tick(5);

      // Single byte, consumer always ready: exact valid latency.
      rx_data_ready = 1'b1;
      exp_q.push_back(8'h55);
      t0 = cyc;
      send_frame(8'h55, 1'b1);
      tick(2);
      check("lat_valid_rise", last_rise - t0, LAT);
      check("t1_level", int'(fifo_level), 0);
      check("t1_frame_err_cnt", n_ferr, 0);
      check("t1_overrun_cnt", n_ovr, 0);

      // Back-to-back message with consumer stalled, then two more to hit full and overrun.
      rx_data_ready = 1'b0;
      foreach (msg[i]) begin
         exp_q.push_back(msg[i]);
         send_frame(msg[i], 1'b1);
      end
      check("msg_level", int'(fifo_level), 15);
      check("msg_head", int'(rx_data), 8'h48);
      check("msg_valid_held", int'(rx_data_valid), 1);
      exp_q.push_back(8'h31);
      send_frame(8'h31, 1'b1);
      send_frame(8'h32, 1'b1);
      check("full_level", int'(fifo_level), 16);
      check("full_head", int'(rx_data), 8'h48);
      check("overrun_cnt", n_ovr, 1);
      rx_data_ready = 1'b1;
      drain("drain_msg");
      check("drain_level", int'(fifo_level), 0);
      check("drain_queue", exp_q.size(), 0);

      // Framing error followed by a long break, then a clean byte.
      base = n_ferr;
      send_frame(8'hA3, 1'b0);
      rx_pin = 1'b0;
      tick(3000);
      rx_pin = 1'b1;
      tick(20);
      check("ferr_cnt", n_ferr - base, 1);
      check("ferr_level", int'(fifo_level), 0);
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b1);
      tick(2);
      drain("after_break");
      check("after_break_queue", exp_q.size(), 0);
      check("after_break_ferr", n_ferr - base, 1);

      // Short low glitch must not produce a byte or an error.
      base = n_ferr;
      rx_pin = 1'b0;
      tick(50);
      rx_pin = 1'b1;
      tick(300);
      check("glitch_level", int'(fifo_level), 0);
      check("glitch_valid", int'(rx_data_valid), 0);
      check("glitch_ferr", n_ferr - base, 0);

      // Reset while frame in progress with three bytes queued.
      rx_data_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      check("pre_rst_level", int'(fifo_level), 3);
      rx_pin = 1'b0;
      tick(BIT);
      rx_pin = 1'b1;
      tick(2 * BIT);
      base = n_ferr;
      rst_n = 1'b0;
      tick(2);
      check("mid_rst_valid", int'(rx_data_valid), 0);
      check("mid_rst_level", int'(fifo_level), 0);
      check("mid_rst_data", int'(rx_data), 0);
      check("mid_rst_ferr", int'(frame_err), 0);
      check("mid_rst_ovr", int'(overrun), 0);
      rst_n = 1'b1;
      tick(10);
      rx_data_ready = 1'b1;
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1);
      tick(2);
      drain("post_rst");
      check("post_rst_queue", exp_q.size(), 0);
      check("post_rst_ferr", n_ferr - base, 0);

`ifdef UART_RX_PARITY_EN
      base = n_perr;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      par_flip = 1'b0;
      tick(5);
      check("perr_cnt", n_perr - base, 1);
      check("perr_level", int'(fifo_level), 0);
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1);
      tick(2);
      drain("par_ok");
      check("par_ok_queue", exp_q.size(), 0);
      check("par_ok_perr", n_perr - base, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
